alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX pipeline stage feeding the Alu: captures a decoded op and presents alu_a/alu_b/alu_mode.
//  Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, detects load-use hazards (holds op).
//  Supports valid/ready back-pressure and flush. Sits between decode and the combinational Alu.
// PARAMETERS
//  WordSize    32  datapath width (matches Alu)
//  RegAddrBits 5   register index width; index 0 is hard-wired zero
//  ModeBits    16  alu_mode width (matches Alu)
// PORTS
//  clk          in   1            clock, all state updates on posedge
//  rstn         in   1            synchronous reset, active-low
//  flush        in   1            kill held op and incoming op
//  dec_valid    in   1            decode offers an op
//  dec_ready    out  1            stage accepts op this cycle
//  dec_rs1/rs2  in   RegAddrBits  source indices
//  dec_rd       in   RegAddrBits  destination index
//  dec_rs1_data in   WordSize     register-file read, rs1
//  dec_rs2_data in   WordSize     register-file read, rs2
//  dec_imm      in   WordSize     immediate
//  dec_use_imm  in   1            b operand = imm; rs2 unused
//  dec_mode     in   ModeBits     ALU mode
//  dec_rd_we    in   1            op writes rd
//  dec_is_load  in   1            op is a load
//  exmem_rd/_we/_is_load/_result  in  RegAddrBits/1/1/WordSize  EX/MEM writeback info
//  memwb_rd/_we/_result           in  RegAddrBits/1/WordSize    MEM/WB writeback info
//  ex_valid     out  1            alu_* hold a hazard-free op
//  ex_ready     in   1            downstream consumes op
//  alu_a/alu_b  out  WordSize     Alu operands (combinational from held op + forwarding)
//  alu_mode     out  ModeBits     held mode
//  ex_rd/ex_rd_we/ex_is_load  out  RegAddrBits/1/1  passed to EX/MEM
// BEHAVIOUR
//  Reset (rstn=0 at posedge): held op invalid, all held fields 0. ex_valid=0, alu_a=alu_b=0.
//   alu_mode=0, ex_rd=0, ex_rd_we=0, ex_is_load=0. dec_ready=1 the cycle after reset.
//  Reset overrides flush, capture and hold.
//  Hit: src!=0 and src==X_rd and X_we. A source is used: rs1 always; rs2 only if !use_imm.
//  Forward priority per operand:
//   1. EX/MEM hit with !exmem_is_load.
//   2. MEM/WB hit.
//   3. Held register data.
//  alu_b = held imm when use_imm.
//  hazard = held_valid & (used source has EX/MEM hit with exmem_is_load).
//  ex_valid = held_valid & !hazard.
//  Outputs are 0 while !held_valid.
//  dec_ready = flush | !held_valid | (ex_ready & !hazard).
//  Zero added latency: op captured at edge N is presented combinationally in cycle N+1.
//  Capture: dec_valid & dec_ready & !flush -> load all dec_* fields and set held_valid.
//  Retire: ex_valid & ex_ready with no capture -> clear held_valid.
//  Simultaneous retire and capture -> the new op replaces the old one. Full throughput, no bubble.
//  Hold (held_valid & !(ex_valid&ex_ready)): each cycle, on a MEM/WB hit, the stage writes
//   memwb_result into held rs1/rs2 data. The value then survives MEM/WB moving on.
//  Flush: held_valid<=0 next edge, incoming op discarded, no capture. Takes priority over hold/retire.
//  Load-use: stall persists while hazard=1. It clears when the load leaves EX/MEM.
//   Its MEM/WB value is then forwarded.
//  x0: never forwarded. Held data for index 0 is used as supplied by decode (0).
// STRUCTURE
//  alu_pkg (shared): Alu opcode constants (ADD, SUB, XOR, OR, AND, LLS, LRS, ARS, SSLT, USLT).
//   Also fwd_sel_e {FWD_REG, FWD_MEMWB, FWD_EXMEM}.
//  Sub-module operand_forward_mux: combinational, one per operand.
//   Inputs: src index, held data, EX/MEM + MEM/WB info.
//   Outputs: forwarded data, fwd_sel_e, load_hit.
//  Top: held-op register, handshake/hazard logic, hold-refresh logic, output zeroing.
// TESTING
//  1 EX/MEM fwd: held rs1=5 data 0x10; exmem rd=5 we=1 load=0 res=0x1234 -> alu_a=0x1234, ex_valid=1.
//  2 Priority/x0: exmem and memwb both rd=5 (0xAAAA/0xBBBB) -> alu_a=0xAAAA.
//    With rs1=0 and exmem rd=0 we=1 -> alu_a=0.
//  3 Load-use: held rs2=7 use_imm=0; exmem rd=7 load=1 -> ex_valid=0, dec_ready=0.
//    Next cycle memwb rd=7 res=0xCAFE, exmem idle -> ex_valid=1, alu_b=0xCAFE.
//  4 use_imm masks hazard: same as 3 with use_imm=1 imm=0x40 -> ex_valid=1, alu_b=0x40.
//  5 Back-pressure capture: ex_ready=0 3 cycles; cycle 1 memwb rd=3 res=0xBEEF, held rs1=3.
//    -> after ex_ready=1, alu_a=0xBEEF. No op lost or duplicated across 10 back-to-back ops.
//  6 Flush/reset: flush with held op and dec_valid=1 -> next cycle ex_valid=0, nothing captured.
//    rstn=0 mid-stall -> next cycle all outputs 0, dec_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the Alu and the stages that feed it.
//   - ALU_* : alu_mode encodings understood by the combinational Alu
//             (one-hot, 16 bits wide to match alu_mode).
//   - fwd_sel_e : which source an operand forwarding mux picked.
package alu_pkg;

  localparam logic [15:0] ALU_ADD  = 16'h0001;
  localparam logic [15:0] ALU_SUB  = 16'h0002;
  localparam logic [15:0] ALU_XOR  = 16'h0004;
  localparam logic [15:0] ALU_OR   = 16'h0008;
  localparam logic [15:0] ALU_AND  = 16'h0010;
  localparam logic [15:0] ALU_LLS  = 16'h0020;
  localparam logic [15:0] ALU_LRS  = 16'h0040;
  localparam logic [15:0] ALU_ARS  = 16'h0080;
  localparam logic [15:0] ALU_SSLT = 16'h0100;
  localparam logic [15:0] ALU_USLT = 16'h0200;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/operand_forward_mux.sv
// operand_forward_mux
//   Combinational RAW-hazard resolution for one Alu operand.
//   Ports:
//     src            in   source register index of the held op
//     held_data      in   register-file value captured with the op
//     exmem_*        in   EX/MEM writeback info (rd, we, is_load, result)
//     memwb_*        in   MEM/WB writeback info (rd, we, result)
//     fwd_data       out  operand value after forwarding
//     fwd_sel        out  which source supplied fwd_data
//     load_hit       out  src is being produced by a load still in EX/MEM
//     memwb_hit      out  src matches the MEM/WB writeback
//   Index 0 never matches, so x0 always comes from held_data.
module operand_forward_mux
  import alu_pkg::*;
#(
  parameter int WordSize    = 32,
  parameter int RegAddrBits = 5
) (
  input  logic [RegAddrBits-1:0] src,
  input  logic [WordSize-1:0]    held_data,
  input  logic [RegAddrBits-1:0] exmem_rd,
  input  logic                   exmem_we,
  input  logic                   exmem_is_load,
  input  logic [WordSize-1:0]    exmem_result,
  input  logic [RegAddrBits-1:0] memwb_rd,
  input  logic                   memwb_we,
  input  logic [WordSize-1:0]    memwb_result,
  output logic [WordSize-1:0]    fwd_data,
  output fwd_sel_e               fwd_sel,
  output logic                   load_hit,
  output logic                   memwb_hit
);

  logic src_nz;
  logic exmem_hit;

  always_comb begin
    src_nz    = |src;
    exmem_hit = src_nz && exmem_we && (src == exmem_rd);
    memwb_hit = src_nz && memwb_we && (src == memwb_rd);
    // A load in EX/MEM has no data yet; it is reported as load_hit and the
    // mux falls through to the older MEM/WB / register value. The stage
    // stalls on load_hit, so that fallback value is never consumed.
    load_hit  = exmem_hit && exmem_is_load;

    fwd_sel  = FWD_REG;
    fwd_data = held_data;
    if (exmem_hit && !exmem_is_load) begin
      fwd_sel  = FWD_EXMEM;
      fwd_data = exmem_result;
    end else if (memwb_hit) begin
      fwd_sel  = FWD_MEMWB;
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   ID/EX stage in front of the combinational Alu. Holds one decoded op,
//   forwards EX/MEM and MEM/WB results into its operands, stalls on
//   load-use, and handshakes with valid/ready on both sides.
//   Ports:
//     clk, rstn                 clock, synchronous active-low reset
//     flush                     kill held op and the op offered this cycle
//     dec_valid/dec_ready       decode handshake
//     dec_rs1/rs2/rd            register indices of the offered op
//     dec_rs1_data/rs2_data     register-file reads
//     dec_imm/dec_use_imm       immediate and b-operand select
//     dec_mode                  Alu mode
//     dec_rd_we/dec_is_load     op writes rd / op is a load
//     exmem_*, memwb_*          writeback info from later stages
//     ex_valid/ex_ready         downstream handshake
//     alu_a/alu_b/alu_mode      Alu operands and mode (0 when empty)
//     ex_rd/ex_rd_we/ex_is_load forwarded to EX/MEM (0 when empty)
//   A captured op appears on the outputs the cycle after capture, with
//   forwarding applied combinationally.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WordSize    = 32,
  parameter int RegAddrBits = 5,
  parameter int ModeBits    = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  input  logic [RegAddrBits-1:0] dec_rs1,
  input  logic [RegAddrBits-1:0] dec_rs2,
  input  logic [RegAddrBits-1:0] dec_rd,
  input  logic [WordSize-1:0]    dec_rs1_data,
  input  logic [WordSize-1:0]    dec_rs2_data,
  input  logic [WordSize-1:0]    dec_imm,
  input  logic                   dec_use_imm,
  input  logic [ModeBits-1:0]    dec_mode,
  input  logic                   dec_rd_we,
  input  logic                   dec_is_load,
  input  logic [RegAddrBits-1:0] exmem_rd,
  input  logic                   exmem_we,
  input  logic                   exmem_is_load,
  input  logic [WordSize-1:0]    exmem_result,
  input  logic [RegAddrBits-1:0] memwb_rd,
  input  logic                   memwb_we,
  input  logic [WordSize-1:0]    memwb_result,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [WordSize-1:0]    alu_a,
  output logic [WordSize-1:0]    alu_b,
  output logic [ModeBits-1:0]    alu_mode,
  output logic [RegAddrBits-1:0] ex_rd,
  output logic                   ex_rd_we,
  output logic                   ex_is_load
);

  logic                   held_valid_q, held_valid_d;
  logic [RegAddrBits-1:0] rs1_q, rs1_d;
  logic [RegAddrBits-1:0] rs2_q, rs2_d;
  logic [RegAddrBits-1:0] rd_q, rd_d;
  logic [WordSize-1:0]    rs1_data_q, rs1_data_d;
  logic [WordSize-1:0]    rs2_data_q, rs2_data_d;
  logic [WordSize-1:0]    imm_q, imm_d;
  logic                   use_imm_q, use_imm_d;
  logic [ModeBits-1:0]    mode_q, mode_d;
  logic                   rd_we_q, rd_we_d;
  logic                   is_load_q, is_load_d;

  logic [WordSize-1:0] fwd_a, fwd_b;
  fwd_sel_e            fwd_sel_a, fwd_sel_b;
  logic                load_hit_a, load_hit_b;
  logic                memwb_hit_a, memwb_hit_b;

  logic hazard;
  logic capture;
  logic retire;

  operand_forward_mux #(
    .WordSize   (WordSize),
    .RegAddrBits(RegAddrBits)
  ) u_fwd_a (
    .src          (rs1_q),
    .held_data    (rs1_data_q),
    .exmem_rd     (exmem_rd),
    .exmem_we     (exmem_we),
    .exmem_is_load(exmem_is_load),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_we     (memwb_we),
    .memwb_result (memwb_result),
    .fwd_data     (fwd_a),
    .fwd_sel      (fwd_sel_a),
    .load_hit     (load_hit_a),
    .memwb_hit    (memwb_hit_a)
  );

  operand_forward_mux #(
    .WordSize   (WordSize),
    .RegAddrBits(RegAddrBits)
  ) u_fwd_b (
    .src          (rs2_q),
    .held_data    (rs2_data_q),
    .exmem_rd     (exmem_rd),
    .exmem_we     (exmem_we),
    .exmem_is_load(exmem_is_load),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_we     (memwb_we),
    .memwb_result (memwb_result),
    .fwd_data     (fwd_b),
    .fwd_sel      (fwd_sel_b),
    .load_hit     (load_hit_b),
    .memwb_hit    (memwb_hit_b)
  );

  // An EX/MEM pick must always carry real data; a load in EX/MEM may
  // never be selected as a forwarding source.
  always_comb begin
    assert (!((fwd_sel_a == FWD_EXMEM) && load_hit_a));
    assert (!((fwd_sel_b == FWD_EXMEM) && load_hit_b));
  end

  // rs2 only matters to hazard detection when b actually comes from it.
  always_comb begin
    hazard    = held_valid_q && (load_hit_a || (load_hit_b && !use_imm_q));
    ex_valid  = held_valid_q && !hazard;
    dec_ready = flush || !held_valid_q || (ex_ready && !hazard);
    capture   = dec_valid && dec_ready && !flush;
    retire    = ex_valid && ex_ready;
  end

  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_mode   = '0;
    ex_rd      = '0;
    ex_rd_we   = 1'b0;
    ex_is_load = 1'b0;
    if (held_valid_q) begin
      alu_a      = fwd_a;
      alu_b      = use_imm_q ? imm_q : fwd_b;
      alu_mode   = mode_q;
      ex_rd      = rd_q;
      ex_rd_we   = rd_we_q;
      ex_is_load = is_load_q;
    end
  end

  always_comb begin
    held_valid_d = held_valid_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    use_imm_d    = use_imm_q;
    mode_d       = mode_q;
    rd_we_d      = rd_we_q;
    is_load_d    = is_load_q;

    if (flush) begin
      held_valid_d = 1'b0;
    end else if (capture) begin
      // Also covers retire+capture in the same cycle: the new op simply
      // overwrites the retiring one.
      held_valid_d = 1'b1;
      rs1_d        = dec_rs1;
      rs2_d        = dec_rs2;
      rd_d         = dec_rd;
      rs1_data_d   = dec_rs1_data;
      rs2_data_d   = dec_rs2_data;
      imm_d        = dec_imm;
      use_imm_d    = dec_use_imm;
      mode_d       = dec_mode;
      rd_we_d      = dec_rd_we;
      is_load_d    = dec_is_load;
    end else if (retire) begin
      held_valid_d = 1'b0;
    end else if (held_valid_q) begin
      // While stalled, soak up MEM/WB results so the value is still
      // correct after that writeback has left the pipeline.
      if (memwb_hit_a) rs1_data_d = memwb_result;
      if (memwb_hit_b) rs2_data_d = memwb_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      held_valid_q <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      mode_q       <= '0;
      rd_we_q      <= 1'b0;
      is_load_q    <= 1'b0;
    end else begin
      held_valid_q <= held_valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      use_imm_q    <= use_imm_d;
      mode_q       <= mode_d;
      rd_we_q      <= rd_we_d;
      is_load_q    <= is_load_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_rs1_data, dec_rs2_data, dec_imm;
  logic        dec_use_imm;
  logic [15:0] dec_mode;
  logic        dec_rd_we, dec_is_load;
  logic [4:0]  exmem_rd;
  logic        exmem_we, exmem_is_load;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_we;
  logic [31:0] memwb_result;
  logic        ex_valid, ex_ready;
  logic [31:0] alu_a, alu_b;
  logic [15:0] alu_mode;
  logic [4:0]  ex_rd;
  logic        ex_rd_we, ex_is_load;

  alu_issue_stage #(.WordSize(32), .RegAddrBits(5), .ModeBits(16)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_mode(dec_mode),
    .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_is_load(exmem_is_load),
    .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    rstn = 1'b1; flush = 1'b0; dec_valid = 1'b0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_rs1_data = '0; dec_rs2_data = '0; dec_imm = '0; dec_use_imm = 1'b0;
    dec_mode = '0; dec_rd_we = 1'b0; dec_is_load = 1'b0;
    exmem_rd = '0; exmem_we = 1'b0; exmem_is_load = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_we = 1'b0; memwb_result = '0;
    ex_ready = 1'b0;
  endtask

  // Empty the stage with a flush, capture one op, return at the following
  // negedge with the op held and all side inputs idle.
  task automatic load_op(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic use_imm);
    @(negedge clk);
    idle_inputs();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    dec_valid = 1'b1;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = 5'd3;
    dec_rs1_data = d1; dec_rs2_data = d2; dec_imm = imm; dec_use_imm = use_imm;
    dec_mode = 16'h0004; dec_rd_we = 1'b1; dec_is_load = 1'b0;
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [4:0]  x_rd;  logic x_we; logic x_ld; logic [31:0] x_res;
    logic [4:0]  w_rd;  logic w_we; logic [31:0] w_res;
    logic        e_valid, e_ready;
    logic [31:0] e_a, e_b;
  } vec_t;

  vec_t vecs[7];

  // Reference model: one held op, forwarding rules evaluated directly.
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [15:0] mode;
    logic        we, ld;
  } op_t;

  op_t m;

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regv);
    if (src != 0 && exmem_we && exmem_rd == src && !exmem_is_load) return exmem_result;
    if (src != 0 && memwb_we && memwb_rd == src) return memwb_result;
    return regv;
  endfunction

  function automatic logic ref_ldhit(input logic [4:0] src);
    return (src != 0) && exmem_we && exmem_is_load && (exmem_rd == src);
  endfunction

  task automatic model_cycle();
    logic hz, exv, dr;
    #1;
    hz  = m.valid && (ref_ldhit(m.rs1) || (!m.use_imm && ref_ldhit(m.rs2)));
    exv = m.valid && !hz;
    dr  = flush || !m.valid || (ex_ready && !hz);
    chk("rnd_ex_valid",  32'(ex_valid),  32'(exv));
    chk("rnd_dec_ready", 32'(dec_ready), 32'(dr));
    chk("rnd_alu_a", alu_a, m.valid ? ref_fwd(m.rs1, m.d1) : 32'd0);
    chk("rnd_alu_b", alu_b, !m.valid ? 32'd0 : (m.use_imm ? m.imm : ref_fwd(m.rs2, m.d2)));
    chk("rnd_alu_mode", 32'(alu_mode), m.valid ? 32'(m.mode) : 32'd0);
    chk("rnd_ex_rd", 32'(ex_rd), m.valid ? 32'(m.rd) : 32'd0);
    chk("rnd_ex_rd_we", 32'(ex_rd_we), m.valid ? 32'(m.we) : 32'd0);
    chk("rnd_ex_is_load", 32'(ex_is_load), m.valid ? 32'(m.ld) : 32'd0);
    if (!rstn) begin
      m = '{default: '0};
    end else if (flush) begin
      m.valid = 1'b0;
    end else if (dec_valid && dr) begin
      m.valid = 1'b1;
      m.rs1 = dec_rs1; m.rs2 = dec_rs2; m.rd = dec_rd;
      m.d1 = dec_rs1_data; m.d2 = dec_rs2_data; m.imm = dec_imm;
      m.use_imm = dec_use_imm; m.mode = dec_mode; m.we = dec_rd_we; m.ld = dec_is_load;
    end else if (exv && ex_ready) begin
      m.valid = 1'b0;
    end else if (m.valid) begin
      if (m.rs1 != 0 && memwb_we && memwb_rd == m.rs1) m.d1 = memwb_result;
      if (m.rs2 != 0 && memwb_we && memwb_rd == m.rs2) m.d2 = memwb_result;
    end
  endtask

  initial begin
    int next_id;
    int cyc;
    int got[$];

    //           rs1 rs2 d1       d2       imm      ui  xrd xwe xld xres          wrd wwe wres          ev  er  ea            eb
    vecs[0] = '{5, 6, 32'h10, 32'h22, 32'h0,  0, 5, 1, 0, 32'h1234, 0, 0, 32'h0,    1, 1, 32'h1234, 32'h22};
    vecs[1] = '{5, 6, 32'h10, 32'h22, 32'h0,  0, 5, 1, 0, 32'hAAAA, 5, 1, 32'hBBBB, 1, 1, 32'hAAAA, 32'h22};
    vecs[2] = '{0, 6, 32'h0,  32'h22, 32'h0,  0, 0, 1, 0, 32'h5555, 0, 1, 32'h6666, 1, 1, 32'h0,    32'h22};
    vecs[3] = '{5, 6, 32'h10, 32'h22, 32'h0,  0, 5, 0, 0, 32'hAAAA, 5, 1, 32'hBBBB, 1, 1, 32'hBBBB, 32'h22};
    vecs[4] = '{1, 7, 32'h11, 32'h3,  32'h0,  0, 7, 1, 1, 32'h9999, 0, 0, 32'h0,    0, 0, 32'h11,   32'h3};
    vecs[5] = '{1, 7, 32'h11, 32'h3,  32'h40, 1, 7, 1, 1, 32'h9999, 0, 0, 32'h0,    1, 1, 32'h11,   32'h40};
    vecs[6] = '{5, 6, 32'h10, 32'h22, 32'h0,  0, 6, 1, 1, 32'h7777, 5, 1, 32'hBBBB, 0, 0, 32'hBBBB, 32'h22};

    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("reset_ex_valid",  32'(ex_valid), 32'd0);
    chk("reset_dec_ready", 32'(dec_ready), 32'd1);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_b", alu_b, 32'd0);
    chk("reset_alu_mode", 32'(alu_mode), 32'd0);
    chk("reset_ex_rd", 32'(ex_rd), 32'd0);

    for (int i = 0; i < 7; i++) begin
      load_op(vecs[i].rs1, vecs[i].rs2, vecs[i].d1, vecs[i].d2, vecs[i].imm, vecs[i].use_imm);
      exmem_rd = vecs[i].x_rd; exmem_we = vecs[i].x_we;
      exmem_is_load = vecs[i].x_ld; exmem_result = vecs[i].x_res;
      memwb_rd = vecs[i].w_rd; memwb_we = vecs[i].w_we; memwb_result = vecs[i].w_res;
      ex_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_dec_ready", i), 32'(dec_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].e_a);
      chk($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].e_b);
    end

    // load-use stall, then the load's value arrives via MEM/WB
    load_op(5'd1, 5'd7, 32'h11, 32'h3, 32'h0, 1'b0);
    exmem_rd = 5'd7; exmem_we = 1'b1; exmem_is_load = 1'b1; exmem_result = 32'h9999;
    ex_ready = 1'b1;
    #1;
    chk("lu_stall_ex_valid", 32'(ex_valid), 32'd0);
    chk("lu_stall_dec_ready", 32'(dec_ready), 32'd0);
    @(negedge clk);
    exmem_we = 1'b0; exmem_is_load = 1'b0;
    memwb_rd = 5'd7; memwb_we = 1'b1; memwb_result = 32'hCAFE;
    #1;
    chk("lu_release_ex_valid", 32'(ex_valid), 32'd1);
    chk("lu_release_alu_b", alu_b, 32'hCAFE);

    // back-pressure: MEM/WB value captured into the held op survives
    load_op(5'd3, 5'd0, 32'h1, 32'h0, 32'h0, 1'b0);
    memwb_rd = 5'd3; memwb_we = 1'b1; memwb_result = 32'hBEEF;
    #1;
    chk("bp_fwd_alu_a", alu_a, 32'hBEEF);
    @(negedge clk);
    memwb_we = 1'b0; memwb_result = 32'h0;
    #1;
    chk("bp_hold_alu_a", alu_a, 32'hBEEF);
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    chk("bp_release_alu_a", alu_a, 32'hBEEF);
    chk("bp_release_ex_valid", 32'(ex_valid), 32'd1);

    // flush kills held op and the offered op
    load_op(5'd2, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0);
    flush = 1'b1; dec_valid = 1'b1; dec_rd = 5'd9; dec_rs1 = 5'd4;
    #1;
    chk("flush_dec_ready", 32'(dec_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0; dec_valid = 1'b0;
    #1;
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    chk("flush_ex_rd", 32'(ex_rd), 32'd0);

    // reset in the middle of a load-use stall
    load_op(5'd1, 5'd7, 32'h11, 32'h3, 32'h0, 1'b0);
    exmem_rd = 5'd7; exmem_we = 1'b1; exmem_is_load = 1'b1;
    ex_ready = 1'b1;
    #1;
    chk("rst_stall_dec_ready", 32'(dec_ready), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_mid_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_mid_alu_a", alu_a, 32'd0);
    chk("rst_mid_alu_b", alu_b, 32'd0);
    chk("rst_mid_alu_mode", 32'(alu_mode), 32'd0);
    chk("rst_mid_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_mid_dec_ready", 32'(dec_ready), 32'd1);

    // 10 back-to-back ops under random back-pressure: none lost or doubled
    @(negedge clk);
    idle_inputs();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    next_id = 1;
    cyc = 0;
    while (got.size() < 10 && cyc < 200) begin
      dec_valid = (next_id <= 10);
      dec_rd = 5'(next_id);
      dec_rd_we = 1'b1;
      ex_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (ex_valid && ex_ready) got.push_back(int'(ex_rd));
      if (dec_valid && dec_ready) next_id++;
      @(negedge clk);
      cyc++;
    end
    chk("b2b_count", 32'(got.size()), 32'd10);
    foreach (got[i]) chk($sformatf("b2b_order%0d", i), 32'(got[i]), 32'(i + 1));

    // randomized run against the reference model
    @(negedge clk);
    idle_inputs();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m = '{default: '0};
    for (int i = 0; i < 1500; i++) begin
      rstn          = ($urandom_range(0, 99) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      dec_valid     = ($urandom_range(0, 9) < 6);
      dec_rs1       = 5'($urandom_range(0, 3));
      dec_rs2       = 5'($urandom_range(0, 3));
      dec_rd        = 5'($urandom_range(0, 3));
      dec_rs1_data  = $urandom;
      dec_rs2_data  = $urandom;
      dec_imm       = $urandom;
      dec_use_imm   = 1'($urandom_range(0, 1));
      dec_mode      = 16'($urandom);
      dec_rd_we     = 1'($urandom_range(0, 1));
      dec_is_load   = 1'($urandom_range(0, 1));
      exmem_rd      = 5'($urandom_range(0, 3));
      exmem_we      = 1'($urandom_range(0, 1));
      exmem_is_load = ($urandom_range(0, 3) == 0);
      exmem_result  = $urandom;
      memwb_rd      = 5'($urandom_range(0, 3));
      memwb_we      = 1'($urandom_range(0, 1));
      memwb_result  = $urandom;
      ex_ready      = ($urandom_range(0, 9) < 7);
      model_cycle();
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
